// File: rtl/store_queue_pkg.sv
// Shared store-queue types and default sizing.
package store_queue_pkg;

  localparam int SQ_WIDTH  = 3;
  localparam int ROB_WIDTH = 5;

  typedef struct packed {
    logic                 busy;
    logic                 addr_valid;
    logic [ROB_WIDTH:0]   robid;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [2:0]           size;
  } sq_entry_type;

endpackage

// File: rtl/store_queue.sv
// In-order store queue: dual-slot allocation, out-of-order execute writeback,
// ROB-driven commit and a single-request drain port to data memory.
module store_queue #(
  parameter int SQ_WIDTH  = store_queue_pkg::SQ_WIDTH,
  parameter int ROB_WIDTH = store_queue_pkg::ROB_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr0_alloc,
  input  logic                  instr1_alloc,
  input  logic [ROB_WIDTH:0]    instr0_robid,
  input  logic [ROB_WIDTH:0]    instr1_robid,
  output logic [1:0]            sq_left,
  output logic [SQ_WIDTH-1:0]   instr0_sqid,
  output logic [SQ_WIDTH-1:0]   instr1_sqid,
  input  logic                  exe_valid,
  input  logic [SQ_WIDTH-1:0]   exe_sqid,
  input  logic [31:0]           exe_addr,
  input  logic [31:0]           exe_data,
  input  logic [2:0]            exe_size,
  input  logic [1:0]            commit_cnt,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [2:0]            mem_size,
  output logic                  sq_empty
);
  import store_queue_pkg::*;

  localparam int SQ_DEPTH = 2 ** SQ_WIDTH;
  typedef logic [SQ_WIDTH:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(SQ_DEPTH);

  ptr_t                head, commit_ptr, tail;
  sq_entry_type        entries [SQ_DEPTH];

  ptr_t                count, free_cnt, alloc_n, pending, commit_amt, commit_next;
  logic                alloc_ok, drain_fire;
  logic [SQ_WIDTH-1:0] head_idx, tail_idx;
  logic [SQ_DEPTH-1:0] flush_kill;
  logic                unused_fields;

  assign head_idx    = head[SQ_WIDTH-1:0];
  assign tail_idx    = tail[SQ_WIDTH-1:0];
  assign count       = tail - head;
  assign free_cnt    = DEPTH_P - count;
  assign sq_left     = (free_cnt > ptr_t'(3)) ? 2'd3 : free_cnt[1:0];
  assign sq_empty    = (head == tail);

  assign instr0_sqid = tail_idx;
  assign instr1_sqid = tail_idx + SQ_WIDTH'(instr0_alloc);

  // An allocation that does not fit entirely is dropped as a whole.
  assign alloc_n     = ptr_t'(instr0_alloc) + ptr_t'(instr1_alloc);
  assign alloc_ok    = !flush && (alloc_n <= free_cnt);

  // Commit never runs past the allocated region.
  assign pending     = tail - commit_ptr;
  assign commit_amt  = (ptr_t'(commit_cnt) > pending) ? pending : ptr_t'(commit_cnt);
  assign commit_next = commit_ptr + commit_amt;

  assign mem_req_valid = (head != commit_ptr);
  assign mem_addr      = entries[head_idx].addr;
  assign mem_wdata     = entries[head_idx].data;
  assign mem_size      = entries[head_idx].size;
  assign drain_fire    = mem_req_valid && mem_req_ready;

  // Entries between the post-commit pointer and the old tail are squashed on flush.
  always_comb begin
    flush_kill = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      logic [SQ_WIDTH-1:0] off;
      off           = SQ_WIDTH'(i) - commit_next[SQ_WIDTH-1:0];
      flush_kill[i] = ({1'b0, off} < (tail - commit_next));
    end
  end

  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++)
      unused_fields = unused_fields ^ (^{entries[i].addr_valid, entries[i].robid});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        entries[i].busy       <= 1'b0;
        entries[i].addr_valid <= 1'b0;
      end
    end else begin
      commit_ptr <= commit_next;
      if (drain_fire) begin
        head                     <= head + ptr_t'(1);
        entries[head_idx].busy   <= 1'b0;
      end
      if (flush) begin
        tail <= commit_next;
        for (int i = 0; i < SQ_DEPTH; i++)
          if (flush_kill[i]) entries[i].busy <= 1'b0;
      end else begin
        if (alloc_ok) begin
          tail <= tail + alloc_n;
          if (instr0_alloc) begin
            entries[instr0_sqid].busy       <= 1'b1;
            entries[instr0_sqid].addr_valid <= 1'b0;
            entries[instr0_sqid].robid      <= instr0_robid;
          end
          if (instr1_alloc) begin
            entries[instr1_sqid].busy       <= 1'b1;
            entries[instr1_sqid].addr_valid <= 1'b0;
            entries[instr1_sqid].robid      <= instr1_robid;
          end
        end
        if (exe_valid && entries[exe_sqid].busy) begin
          entries[exe_sqid].addr_valid <= 1'b1;
          entries[exe_sqid].addr       <= exe_addr;
          entries[exe_sqid].data       <= exe_data;
          entries[exe_sqid].size       <= exe_size;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue with SQ_WIDTH=3 (8 entries).
module tb_store_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr0_alloc, instr1_alloc;
  logic [5:0]  instr0_robid, instr1_robid;
  logic [1:0]  sq_left;
  logic [2:0]  instr0_sqid, instr1_sqid;
  logic        exe_valid;
  logic [2:0]  exe_sqid;
  logic [31:0] exe_addr, exe_data;
  logic [2:0]  exe_size;
  logic [1:0]  commit_cnt;
  logic        flush;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        sq_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int ids [20];
  int drained;

  always #5 clk = ~clk;

  store_queue #(.SQ_WIDTH(3), .ROB_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr0_alloc(instr0_alloc), .instr1_alloc(instr1_alloc),
    .instr0_robid(instr0_robid), .instr1_robid(instr1_robid),
    .sq_left(sq_left), .instr0_sqid(instr0_sqid), .instr1_sqid(instr1_sqid),
    .exe_valid(exe_valid), .exe_sqid(exe_sqid), .exe_addr(exe_addr),
    .exe_data(exe_data), .exe_size(exe_size),
    .commit_cnt(commit_cnt), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .sq_empty(sq_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr0_alloc  = 1'b0;
    instr1_alloc  = 1'b0;
    instr0_robid  = '0;
    instr1_robid  = '0;
    exe_valid     = 1'b0;
    exe_sqid      = '0;
    exe_addr      = '0;
    exe_data      = '0;
    exe_size      = '0;
    commit_cnt    = 2'd0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  task automatic alloc(input logic a0, input logic a1);
    instr0_alloc = a0;
    instr1_alloc = a1;
    step();
    idle();
  endtask

  task automatic exe(input int sqid, input logic [31:0] addr, input logic [31:0] data);
    exe_valid = 1'b1;
    exe_sqid  = 3'(sqid);
    exe_addr  = addr;
    exe_data  = data;
    exe_size  = 3'd2;
    step();
    idle();
  endtask

  task automatic drain_expect(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!mem_req_valid && n < 10) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
    check(tag, mem_addr, addr);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;

    // Reset state
    check("rst_sq_left", 32'(sq_left), 32'd3);
    check("rst_empty",   32'(sq_empty), 32'd1);
    check("rst_valid",   32'(mem_req_valid), 32'd0);
    check("rst_sqid0",   32'(instr0_sqid), 32'd0);
    check("rst_sqid1",   32'(instr1_sqid), 32'd0);

    // Dual allocation
    instr0_alloc = 1'b1; instr0_robid = 6'd5;
    instr1_alloc = 1'b1; instr1_robid = 6'd6;
    #1;
    check("alloc_sqid0", 32'(instr0_sqid), 32'd0);
    check("alloc_sqid1", 32'(instr1_sqid), 32'd1);
    step(); idle();
    check("next_sqid0", 32'(instr0_sqid), 32'd2);
    check("next_empty", 32'(sq_empty), 32'd0);

    // Execute + commit in one cycle
    exe_valid = 1'b1; exe_sqid = 3'd0; exe_addr = 32'h100; exe_data = 32'hAA; exe_size = 3'd2;
    commit_cnt = 2'd1;
    step(); idle();
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_addr",  mem_addr, 32'h100);
    check("req_data",  mem_wdata, 32'hAA);
    check("req_size",  32'(mem_size), 32'd2);

    // Backpressure holds the request
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(mem_req_valid), 32'd1);
      check("hold_addr",  mem_addr, 32'h100);
      check("hold_data",  mem_wdata, 32'hAA);
    end
    mem_req_ready = 1'b1;
    step(); idle();
    check("drained_valid", 32'(mem_req_valid), 32'd0);
    check("drained_empty", 32'(sq_empty), 32'd0);

    // Flush discards the uncommitted entry 1
    flush = 1'b1;
    step(); idle();
    check("flush_empty", 32'(sq_empty), 32'd1);
    check("flush_sqid0", 32'(instr0_sqid), 32'd1);

    // Fill to 7, dropped overflow, fill to 8
    alloc(1'b1, 1'b1); alloc(1'b1, 1'b1); alloc(1'b1, 1'b1); alloc(1'b1, 1'b0);
    check("fill7_left",  32'(sq_left), 32'd1);
    check("fill7_sqid0", 32'(instr0_sqid), 32'd0);
    instr0_alloc = 1'b1; instr1_alloc = 1'b1;
    #1;
    check("drop_sqid1", 32'(instr1_sqid), 32'd1);
    step(); idle();
    check("drop_left",  32'(sq_left), 32'd1);
    check("drop_sqid0", 32'(instr0_sqid), 32'd0);
    alloc(1'b1, 1'b0);
    check("full_left",  32'(sq_left), 32'd0);
    check("full_empty", 32'(sq_empty), 32'd0);
    check("full_sqid0", 32'(instr0_sqid), 32'd1);

    for (int j = 0; j < 8; j++) exe((1 + j) % 8, 32'h200 + 32'(j * 4), 32'(j));
    for (int j = 0; j < 4; j++) begin
      commit_cnt = 2'd2;
      step(); idle();
    end
    for (int j = 0; j < 8; j++) drain_expect("full_drain", 32'h200 + 32'(j * 4));
    check("full_after_empty", 32'(sq_empty), 32'd1);
    check("full_after_left",  32'(sq_left), 32'd3);

    // 4 allocs, 2 committed (one in the flush cycle), then flush
    alloc(1'b1, 1'b1); alloc(1'b1, 1'b1);
    for (int j = 0; j < 4; j++) exe(1 + j, 32'h300 + 32'(j * 4), 32'(j));
    commit_cnt = 2'd1;
    step(); idle();
    flush = 1'b1; commit_cnt = 2'd1; instr0_alloc = 1'b1;
    exe_valid = 1'b1; exe_sqid = 3'd1; exe_addr = 32'hDEAD; exe_data = 32'hDEAD;
    step(); idle();
    check("flush2_sqid0", 32'(instr0_sqid), 32'd3);
    check("flush2_valid", 32'(mem_req_valid), 32'd1);
    drain_expect("flush2_drain0", 32'h300);
    drain_expect("flush2_drain1", 32'h304);
    check("flush2_after_valid", 32'(mem_req_valid), 32'd0);
    check("flush2_empty",       32'(sq_empty), 32'd1);

    // Commit count larger than outstanding stores is clamped
    alloc(1'b1, 1'b0);
    exe_valid = 1'b1; exe_sqid = 3'd3; exe_addr = 32'h400; exe_data = 32'h44;
    commit_cnt = 2'd2;
    step(); idle();
    instr0_alloc = 1'b1;
    check("clamp_addr", mem_addr, 32'h400);
    mem_req_ready = 1'b1;
    step(); idle();
    check("clamp_valid", 32'(mem_req_valid), 32'd0);
    check("clamp_empty", 32'(sq_empty), 32'd0);
    commit_cnt = 2'd1;
    step(); idle();
    mem_req_ready = 1'b1;
    step(); idle();
    check("clamp_after_empty", 32'(sq_empty), 32'd1);

    // Pipelined alloc/execute/commit/drain across pointer wrap
    drained = 0;
    for (int k = 0; k < 25; k++) begin
      idle();
      if (k < 20) begin
        instr0_alloc = 1'b1;
        instr0_robid = 6'(k);
        check("wrap_sqid", 32'(instr0_sqid), 32'((13 + k) % 8));
        ids[k] = (13 + k) % 8;
      end
      if (k >= 1 && k <= 20) begin
        exe_valid = 1'b1;
        exe_sqid  = 3'(ids[k-1]);
        exe_addr  = 32'h1000 + 32'((k - 1) * 4);
        exe_data  = 32'(k - 1);
      end
      if (k >= 2 && k <= 21) commit_cnt = 2'd1;
      mem_req_ready = 1'b1;
      if (mem_req_valid) begin
        check("wrap_order", mem_addr, 32'h1000 + 32'(drained * 4));
        drained++;
      end
      step();
    end
    idle();
    check("wrap_count", 32'(drained), 32'd20);
    check("wrap_empty", 32'(sq_empty), 32'd1);
    check("wrap_sqid_end", 32'(instr0_sqid), 32'd1);

    // Reset while a request is pending
    alloc(1'b1, 1'b0);
    exe(1, 32'h500, 32'h55);
    commit_cnt = 2'd1;
    step(); idle();
    reset_n = 1'b0; mem_req_ready = 1'b1;
    step();
    reset_n = 1'b1; mem_req_ready = 1'b0;
    check("rst2_valid", 32'(mem_req_valid), 32'd0);
    check("rst2_empty", 32'(sq_empty), 32'd1);
    check("rst2_sqid0", 32'(instr0_sqid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter SQ_WIDTH, default from common package, index width; SQ_DEPTH = 2**SQ_WIDTH entries.
REQ-002 Parameter ROB_WIDTH, default from common package; ROB ids are ROB_WIDTH+1 bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset is synchronous and active-low.
REQ-005 instr0_alloc, instr1_alloc  in  1 each  dispatch slot holds a store accepted this cycle.
REQ-006 instr0_robid, instr1_robid  in  ROB_WIDTH+1 each  ROB id of each allocating store.
REQ-007 sq_left  out  2  free entries, saturated at 3.
REQ-008 instr0_sqid, instr1_sqid  out  SQ_WIDTH each  entry index granted to slot 0/1.
REQ-009 exe_valid, exe_sqid[SQ_WIDTH-1:0], exe_addr[31:0], exe_data[31:0], exe_size[2:0]  in  store execute writeback.
REQ-010 commit_cnt  in  2  number of oldest stores retired by ROB this cycle (0..2).
REQ-011 flush  in  1  squash all uncommitted entries.
REQ-012 mem_req_valid out 1, mem_req_ready in 1, mem_addr out 32, mem_wdata out 32, mem_size out 3  drain port to data memory.
REQ-013 sq_empty  out  1  no occupied entries.

Function
REQ-014 State: circular buffer; pointers head, commit_ptr, tail each SQ_WIDTH+1 bits (wrap bit); order head <= commit_ptr <= tail.
REQ-015 count = tail - head (modulo 2**(SQ_WIDTH+1)); full when count == SQ_DEPTH; empty when count == 0.
REQ-016 sq_left = min(SQ_DEPTH - count, 3), from registered state only (same-cycle drain not credited).
REQ-017 instr0_sqid = tail[SQ_WIDTH-1:0]; instr1_sqid = (tail + instr0_alloc)[SQ_WIDTH-1:0]; combinational, valid every cycle.
REQ-018 Allocation: each allocating slot writes robid, clears addr_valid, sets busy; tail advances by instr0_alloc + instr1_alloc next cycle.
REQ-019 Allocation exceeding free space is dropped whole (tail unchanged); legal dispatch never causes it.
REQ-020 Execute: exe_valid writes addr/data/size into entry exe_sqid and sets addr_valid; ignored if entry not busy.
REQ-021 Commit: commit_ptr advances by commit_cnt, clamped to tail; committed entries are immune to flush.
REQ-022 Drain: mem_req_valid = (head != commit_ptr); mem_addr/wdata/size driven from entry head.
REQ-023 Handshake: request held stable until mem_req_valid & mem_req_ready; on that edge head advances 1, entry busy cleared; max one drain per cycle.
REQ-024 Flush: tail <= commit_ptr + (commit_cnt that cycle); allocations and exe writes in flush cycle ignored; uncommitted busy bits cleared.
REQ-025 Simultaneous alloc, execute, commit and drain in one cycle all take effect independently.
REQ-026 Pointer wrap: increments roll over SQ_DEPTH cleanly; full vs empty distinguished by wrap bit.
REQ-027 sq_empty = (head == tail).

Reset
REQ-028 On reset_n low at rising edge: head, commit_ptr, tail = 0; all busy/addr_valid = 0.
REQ-029 Outputs after reset: mem_req_valid 0, sq_left 3 (SQ_DEPTH >= 3), sq_empty 1, instr0_sqid 0, instr1_sqid 0.
REQ-030 Reset mid-drain aborts any pending request; no handshake completes in reset cycle.

Structure
REQ-031 sq_entry_type (busy, addr_valid, robid, addr, data, size) typedef and SQ_WIDTH belong in common package.
REQ-032 Single flat module; no sub-module is natural.

Verification (SQ_WIDTH=3, DEPTH=8)
REQ-033 Reset, idle -> sq_left=3, sq_empty=1, mem_req_valid=0.
REQ-034 Dual alloc robids 5,6 -> sqids 0,1; next cycle instr0_sqid=2; exe to sqid 0 addr 0x100 data 0xAA, commit_cnt=1 -> mem_req_valid=1, mem_addr=0x100, mem_wdata=0xAA.
REQ-035 mem_req_ready=0 for 3 cycles -> outputs stable; ready=1 -> head=1 next cycle, mem_req_valid=0.
REQ-036 Fill to 7 entries -> sq_left=1; dual alloc attempted -> dropped, tail unchanged; fill to 8 -> sq_left=0.
REQ-037 4 allocs, 2 committed, flush -> tail=commit_ptr, both committed entries still drain in order.
REQ-038 Run 20 alloc/commit/drain cycles -> pointers wrap past 7, sqids continue 0,1..., no lost or duplicated stores.
